// File: rtl/rv32i_types.sv
// Shared types for the cache-to-burst-memory path.
// State encoding and line geometry for the cacheline adapter.
package rv32i_types;

    localparam int LINE_W    = 256;
    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        RESP,
        GAP
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Turns 256-bit line reads/writes from the cache into 4-beat
// 64-bit bursts on bmem, returning the line with a one-cycle resp.
module cacheline_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 dfp_addr,
    input  logic                        dfp_read,
    input  logic                        dfp_write,
    input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata,
    output logic                        dfp_resp,
    output logic [31:0]                 bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [31:0]                 bmem_raddr,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
);
    import rv32i_types::*;

    localparam int            CW   = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    adapter_state_t state;
    adapter_state_t state_next;

    logic [CW-1:0]                     cnt;
    logic [26:0]                       line;
    logic [BEAT_W*BURST_LEN-1:0]       wline;
    logic [BEAT_W*BURST_LEN-1:0]       rline;
    logic [BEAT_W*(BURST_LEN-1)-1:0]   rbuf;
    logic                              hit;
    logic                              beat_ok;
    logic                              unused_ok;

    assign unused_ok = ^dfp_addr[4:0];
    assign hit = bmem_rvalid && (bmem_raddr == {line, 5'b0});

    always_comb begin
        state_next = state;
        beat_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_next = WR_DATA;
                end else if (dfp_read) begin
                    state_next = RD_CMD;
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                beat_ok = hit;
                if (hit && cnt == LAST) begin
                    state_next = RESP;
                end
            end
            WR_DATA: begin
                beat_ok = bmem_ready;
                if (bmem_ready && cnt == LAST) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bmem_addr  = {line, 5'b0};
        bmem_read  = (state == RD_CMD);
        bmem_write = (state == WR_DATA);
        bmem_wdata = wline[cnt*BEAT_W +: BEAT_W];
        dfp_resp   = (state == RESP);
        dfp_rdata  = rline;
    end

    // Beats 0..N-2 collect in rbuf so dfp_rdata only changes on RESP entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            line  <= '0;
            wline <= '0;
            rline <= '0;
            rbuf  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                cnt <= '0;
                if (dfp_write || dfp_read) begin
                    line <= dfp_addr[31:5];
                end
                if (dfp_write) begin
                    wline <= dfp_wdata;
                end
            end else if (beat_ok) begin
                cnt <= cnt + 1'b1;
                if (state == RD_DATA) begin
                    if (cnt == LAST) begin
                        rline <= {bmem_rdata, rbuf};
                    end else begin
                        rbuf[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
                    end
                end
            end
        end
    end

    // The cache must never raise both requests; write wins if it does.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            assert (!(dfp_read && dfp_write))
            else $warning("cacheline_adapter: read and write both high, write taken");
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized + directed bench for cacheline_adapter, checked every
// cycle against a transaction-level model of the adapter.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  dfp_addr = '0;
    logic         dfp_read = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
        .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: what the adapter owes the cache and memory.
    bit           m_valid = 0;
    bit           m_busy = 0;
    bit           m_wr = 0;
    bit           m_cmd = 0;
    bit           m_resp = 0;
    bit           m_gap = 0;
    int           m_n = 0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wline = '0;
    logic [255:0] m_line = '0;
    logic [63:0]  m_beats [4];

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_busy = 0; m_resp = 0; m_gap = 0; m_n = 0;
            m_addr = '0; m_wline = '0; m_line = '0;
        end else if (m_resp) begin
            m_resp = 0;
            m_gap  = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_busy) begin
            if (dfp_write || dfp_read) begin
                m_busy = 1;
                m_wr   = dfp_write;
                m_cmd  = 0;
                m_n    = 0;
                m_addr = {dfp_addr[31:5], 5'b0};
                if (dfp_write) m_wline = dfp_wdata;
            end
        end else if (m_wr) begin
            if (bmem_ready) m_n++;
            if (m_n == 4) begin m_busy = 0; m_resp = 1; end
        end else if (!m_cmd) begin
            if (bmem_ready) m_cmd = 1;
        end else begin
            if (bmem_rvalid && bmem_raddr == m_addr) begin
                m_beats[m_n] = bmem_rdata;
                m_n++;
            end
            if (m_n == 4) begin
                m_busy = 0;
                m_resp = 1;
                m_line = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("dfp_resp", dfp_resp, m_resp);
            chk("dfp_rdata", dfp_rdata, m_line);
            chk("bmem_read", bmem_read, m_busy && !m_wr && !m_cmd);
            chk("bmem_write", bmem_write, m_busy && m_wr);
            chk("bmem_addr", bmem_addr, m_addr);
            if (m_busy && m_wr)
                chk("bmem_wdata", bmem_wdata, m_wline[m_n*64 +: 64]);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_resp"}, dfp_resp, 0);
        chk({tag, "_rdata"}, dfp_rdata, 0);
        chk({tag, "_rd"}, bmem_read, 0);
        chk({tag, "_wr"}, bmem_write, 0);
        chk({tag, "_addr"}, bmem_addr, 0);
        chk({tag, "_wdata"}, bmem_wdata, 0);
    endtask

    // Cache side holds the request through RESP, then drops it.
    task automatic do_txn(input bit wr, input logic [31:0] a,
                          input logic [255:0] wd, input int rdy_pct);
        logic [31:0] ln;
        bit seen;
        int rd_seen;
        ln = {a[31:5], 5'b0};
        seen = 0;
        rd_seen = 0;
        dfp_addr = a;
        dfp_wdata = wd;
        dfp_write = wr;
        dfp_read = !wr;
        for (int c = 0; c < 400; c++) begin
            bmem_ready  = ($urandom_range(99) < rdy_pct);
            bmem_rvalid = ($urandom_range(99) < 60);
            bmem_raddr  = ($urandom_range(9) == 0) ? (ln ^ 32'h100) : ln;
            bmem_rdata  = {$urandom, $urandom};
            step();
            if (wr && bmem_read) rd_seen++;
            if (dfp_resp) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL txn_timeout: got no resp want resp addr %h", a);
            rst = 1; step(); rst = 0;
        end else begin
            if (wr) chk("no_dup_read", rd_seen, 0);
            step();
        end
        dfp_read = 0;
        dfp_write = 0;
        bmem_rvalid = 0;
    endtask

    bit          t2_rdy [6];
    logic [63:0] t2_exp [6];
    logic [31:0] t3_tag [5];
    logic [63:0] t3_dat [5];
    logic [63:0] wa, wb, wc, wd4;
    bit          rw;
    logic [31:0] ra;
    logic [255:0] rwd;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        step(); step();
        check_zero("reset");
        rst = 0;
        step();

        // Read without stalls: resp six cycles after IDLE samples it.
        dfp_addr = 32'h1234_5678; dfp_read = 1;
        bmem_ready = 1; bmem_rvalid = 0; bmem_raddr = 32'h1234_5660;
        step();
        chk("t1_cmd", bmem_read, 1);
        chk("t1_addr", bmem_addr, 32'h1234_5660);
        step();
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1;
            bmem_rdata = {16{4'(b + 1)}};
            step();
        end
        bmem_rvalid = 0;
        chk("t1_resp", dfp_resp, 1);
        chk("t1_rdata", dfp_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        chk("t1_model", m_line,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        step();
        chk("t1_gap", dfp_resp, 0);
        dfp_read = 0;
        step();

        // Write with ready stalls: held beat repeats.
        wa = 64'hA0A0_A0A0_A0A0_A0A0; wb = 64'hB1B1_B1B1_B1B1_B1B1;
        wc = 64'hC2C2_C2C2_C2C2_C2C2; wd4 = 64'hD3D3_D3D3_D3D3_D3D3;
        t2_rdy = '{1, 0, 1, 1, 0, 1};
        t2_exp = '{wa, wb, wb, wc, wd4, wd4};
        dfp_addr = 32'h8000_0040; dfp_wdata = {wd4, wc, wb, wa};
        dfp_write = 1; bmem_ready = 0;
        step();
        for (int i = 0; i < 6; i++) begin
            bmem_ready = t2_rdy[i];
            chk("t2_wvld", bmem_write, 1);
            chk("t2_beat", bmem_wdata, t2_exp[i]);
            chk("t2_addr", bmem_addr, 32'h8000_0040);
            step();
        end
        chk("t2_resp", dfp_resp, 1);
        dfp_wdata = '0;
        step();
        dfp_write = 0;
        step();

        // Foreign-tag beat mid-burst is skipped.
        t3_tag = '{32'h200, 32'h100, 32'h200, 32'h200, 32'h200};
        t3_dat = '{64'h0000_0000_0000_00B0, 64'hDEAD_BEEF_DEAD_BEEF,
                   64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00B2,
                   64'h0000_0000_0000_00B3};
        dfp_addr = 32'h0000_021C; dfp_read = 1; bmem_ready = 1; bmem_rvalid = 0;
        step();
        chk("t3_addr", bmem_addr, 32'h0000_0200);
        step();
        for (int i = 0; i < 5; i++) begin
            bmem_rvalid = 1;
            bmem_raddr = t3_tag[i];
            bmem_rdata = t3_dat[i];
            step();
            if (i == 3) chk("t3_no_early", dfp_resp, 0);
        end
        bmem_rvalid = 0;
        chk("t3_resp", dfp_resp, 1);
        chk("t3_rdata", dfp_rdata,
            256'h00000000000000B3_00000000000000B2_00000000000000B1_00000000000000B0);
        step();
        dfp_read = 0;
        step();

        // Both requests at once: write wins.
        dfp_addr = 32'h0000_0A00; dfp_wdata = {8{32'h5A5A_0F0F}};
        dfp_read = 1; dfp_write = 1; bmem_ready = 1;
        step();
        chk("t4_write", bmem_write, 1);
        chk("t4_noread", bmem_read, 0);
        step(); step(); step(); step();
        chk("t4_resp", dfp_resp, 1);
        chk("t4_rdata_held", dfp_rdata,
            256'h00000000000000B3_00000000000000B2_00000000000000B1_00000000000000B0);
        step();
        dfp_read = 0; dfp_write = 0;
        step();

        // Reset after two read beats; stragglers are dropped.
        dfp_addr = 32'h0000_0400; dfp_read = 1; bmem_ready = 1;
        bmem_rvalid = 0; bmem_raddr = 32'h0000_0400;
        step(); step();
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1;
            bmem_rdata = {16{4'(b + 7)}};
            step();
        end
        rst = 1; dfp_read = 0;
        step();
        check_zero("t5");
        rst = 0;
        step(); step();
        bmem_rvalid = 0;
        chk("t5_idle_rd", bmem_read, 0);
        chk("t5_idle_resp", dfp_resp, 0);
        do_txn(0, 32'h0000_0400, '0, 100);

        // Back-to-back read then write.
        do_txn(0, 32'h0000_3300, '0, 70);
        do_txn(1, 32'h0000_3300, {8{32'hCAFE_F00D}}, 70);

        for (int t = 0; t < 40; t++) begin
            rw = $urandom_range(1);
            ra = $urandom;
            for (int k = 0; k < 8; k++) rwd[k*32 +: 32] = $urandom;
            do_txn(rw, ra, rwd, int'($urandom_range(100, 30)));
            if ($urandom_range(3) == 0) step();
        end
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Memory-side responder for the cache's 256-bit downward-facing port (dfp_*); one instance sits behind each cache, or behind the arbiter that shares them.
- Converts each full-line read or write into a 4-beat, 64-bit burst on the burst-memory (bmem_*) interface.
- Returns the assembled line, or write completion, to the cache with a single-cycle dfp_resp.

Parameters:
- BEAT_W, 64, width of one bmem data beat.
- BURST_LEN, 4, beats per cache line; BEAT_W*BURST_LEN must equal 256.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- dfp_addr  in  32  line address from the cache; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  write line
- dfp_rdata  out  256  read line, valid while dfp_resp=1
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, always {line[31:5],5'b0}
- bmem_read  out  1  read burst command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts command/beat this cycle
- bmem_raddr  in  32  address tag of returning beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - All outputs are 0 after reset, state=IDLE, beat counter=0.
  - Reset mid-burst returns to IDLE; any bmem beats still in flight are dropped, because IDLE ignores bmem_rvalid.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP, GAP.
- IDLE:
  - If dfp_write=1, latch the line address and dfp_wdata, clear the counter, and go to WR_DATA.
  - Otherwise, if dfp_read=1, latch the address and go to RD_CMD.
  - Write has priority when both are asserted; simultaneous assertion is a protocol violation, assert-flagged in simulation only.
- RD_CMD:
  - bmem_read=1 with bmem_addr set to the latched line address.
  - Held until bmem_ready=1; in that cycle the command is accepted and the next state is RD_DATA.
- RD_DATA:
  - On bmem_rvalid=1 with bmem_raddr equal to the latched address, store bmem_rdata into line bits [64*cnt+63 : 64*cnt] and increment cnt.
  - A bmem_rvalid with a non-matching bmem_raddr is ignored.
  - When the beat at cnt=3 is stored, go to RESP.
  - Gaps between beats are allowed.
- WR_DATA:
  - bmem_write=1, bmem_addr=line address, bmem_wdata=wline[64*cnt+63 : 64*cnt].
  - cnt advances only in cycles with bmem_ready=1; while ready=0, the same beat is held.
  - Beat 3 accepted → RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle; dfp_rdata is the assembled line (reads) and holds its value outside RESP.
  - Always goes to GAP.
- GAP:
  - One idle cycle; dfp_read/dfp_write are ignored, since the cache drops its request the cycle after seeing resp.
  - Goes to IDLE.
- Counter: 2 bits, wraps 3→0 and is cleared on every IDLE exit.
- Latency:
  - Read with ready=1 and back-to-back rvalid: request seen (IDLE) → RD_CMD → 4 data cycles → RESP, giving dfp_resp 6 cycles after IDLE samples the request, plus memory latency.
  - Write with ready=1: IDLE → 4 WR_DATA cycles → RESP, giving dfp_resp 5 cycles after IDLE.
- Addressing: bmem_addr[4:0]=0 always; dfp_addr is not re-sampled during a transaction.
- Changes to dfp_wdata after the IDLE capture have no effect.

Decomposition:
- Shared package (rv32i_types):
  - adapter_state_t enum (IDLE, RD_CMD, RD_DATA, WR_DATA, RESP, GAP).
  - Constants LINE_W=256, BEAT_W=64, BURST_LEN=4.
- Single module; the beat shift/assembly datapath is simple enough to stay inline. No sub-module.

Test Plan:
- Read, no stalls: dfp_read with addr=0x1234_5678; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → bmem_addr=0x1234_5660; dfp_rdata={0x44..,0x33..,0x22..,0x11..}; dfp_resp is 1 for one cycle; then GAP.
- Write with ready stalls: dfp_write, addr=0x8000_0040, wdata = beats A,B,C,D; bmem_ready toggles 1,0,1,1,0,1 → beats appear in order A,B,B,C,D,D; exactly 4 accepted beats; one dfp_resp after D is accepted.
- Read with mismatched tag: an rvalid with raddr=0x0000_0100 arrives mid-burst of line 0x0000_0200 → that beat is ignored; the line assembles only from matching beats; dfp_resp is delayed accordingly.
- Simultaneous read+write in IDLE → a write burst is issued, not a read; the simulation assertion fires.
- Reset after the 2nd read beat → all outputs are 0 the next cycle; the remaining rvalid beats are ignored; a subsequent fresh read completes correctly.
- Back-to-back requests: the cache holds dfp_read through the RESP cycle and deasserts it next cycle, then asserts dfp_write → no duplicate read; the write starts from IDLE after GAP.
